sc_sng_pair: RTL and testbench
==============================

Name: sc_sng_pair

Overview:
- Dual-lane stochastic number generator: the stage directly upstream of the stochastic multiplier/accumulator.
- Captures two binary operands on a start request, then emits two unipolar bitstreams of BSL bits each, one bit pair per accepted transfer.
- Each lane has its own maximal-length LFSR and comparator.
- Has a valid/ready stream interface, so the downstream AND/accumulate stage can stall it.

Parameters:
- WIDTH, 8: operand and LFSR width.
- BSL, 255: bitstream length in bits; legal range 1 .. 2**WIDTH-1.
- SEED_A, 8'd1: lane A LFSR reload value; must be nonzero.
- SEED_B, 8'd244: lane B LFSR reload value; must be nonzero.
- TAPS_A, 8'b1000_1110: lane A feedback mask (bits 7,3,2,1). Must give a maximal-length sequence.
- TAPS_B, 8'b1001_0101: lane B feedback mask (bits 7,4,2,0). Must give a maximal-length sequence.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  request a new stream; sampled only in IDLE.
- a  in  WIDTH  lane A operand; captured when start is accepted.
- b  in  WIDTH  lane B operand; captured when start is accepted.
- idle  out  1  high in IDLE; start is accepted only when this is high.
- bit_valid  out  1  a_bit, b_bit and bit_last are valid.
- bit_ready  in  1  downstream accepts the current bit pair.
- a_bit  out  1  lane A stochastic bit.
- b_bit  out  1  lane B stochastic bit.
- bit_last  out  1  marks the final (BSL-th) bit pair.
- done  out  1  one-cycle pulse after the last transfer.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, idle = 1.
  - bit_valid, a_bit, b_bit, bit_last, done = 0.
  - lfsr_a = SEED_A, lfsr_b = SEED_B.
  - Index counter = 0; captured operands = 0.
- Transfer: a cycle with bit_valid && bit_ready.
- States:
  - IDLE: start=1 captures a and b into a_q and b_q, reloads both LFSRs with their seeds, clears the counter, and moves to RUN next cycle. First bit_valid appears 1 cycle after start.
  - RUN: bit_valid = 1.
    - a_bit = (a_q > lfsr_a), b_bit = (b_q > lfsr_b). Strict unsigned compare, combinational from registers.
    - bit_last = (counter == BSL-1).
    - On transfer: each LFSR shifts left and inserts XOR(lfsr & TAPS) at bit 0; counter += 1.
    - On a transfer with bit_last = 1: go to IDLE and pulse done the next cycle.
    - Without bit_ready, all outputs and state hold (stall for any number of cycles).
- Statistics: with a maximal LFSR and BSL = 255, the lane ones-count equals max(operand-1, 0).
- Boundary conditions:
  - start while RUN is ignored; a and b changing mid-stream have no effect.
  - start in the same cycle as the final transfer is ignored; start is accepted only once idle = 1 is observed.
  - BSL = 1: a single transfer with bit_last = 1.
  - Counter never wraps; width is $clog2(BSL+1).
  - Reset mid-stream aborts immediately to reset values, with no done pulse.
  - done and bit_valid are never high in the same cycle.

Optional Feature:
- SC_SNG_SEED_LOAD_EN defined:
  - Adds ports seed_a and seed_b (in, WIDTH each).
  - Both are captured on an accepted start and used as the LFSR reload values instead of SEED_A/SEED_B.
  - A captured seed of 0 is replaced by the parameter seed, so the LFSR never locks up.
- Undefined: no extra ports; parameter seeds are always used.

Decomposition:
- Package sc_pkg holds:
  - WIDTH and BSL defaults.
  - Default seeds and tap masks.
  - The state enum (IDLE, RUN).
  - Shared with the multiplier and accumulator stages.
- Sub-module sc_lfsr: one instance per lane.
  - Parameters: WIDTH, TAPS, SEED.
  - Inputs: load, load_val, step.
  - Output: state.

Test Plan:
- Reset then start with a=128, b=128, bit_ready tied 1:
  - First bit_valid 1 cycle after start; exactly 255 transfers.
  - bit_last only on the 255th transfer; done pulses once, 1 cycle later.
  - ones(a_bit) = 127 and ones(b_bit) = 127.
- a=0, b=255: ones(a_bit) = 0 and ones(b_bit) = 254. Each lane's LFSR visits all 255 nonzero values exactly once and returns to its seed.
- Random bit_ready (~50%) with a=200, b=37: counts are identical to the always-ready run (199, 36), and outputs hold stable during every stall.
- start pulsed during RUN and during the final transfer with different a values: both are ignored; the counts reflect the original operands.
- rst asserted at transfer 100:
  - All outputs drop to their reset values asynchronously; no done pulse.
  - A subsequent start yields a full 255-bit stream.
- With SC_SNG_SEED_LOAD_EN: seed_a=0x5A gives a first lane A compare against 0x5A; seed_a=0 falls back to SEED_A; counts are unchanged (127 for a=128).

Source files
------------

// File: rtl/sc_pkg.sv
// ============================================================================
// sc_pkg : shared defaults, seeds, taps and state type for the SC pipeline
// Revision: 1.0
// ============================================================================
`default_nettype none

package sc_pkg;

    localparam int SC_WIDTH = 8;
    localparam int SC_BSL   = 255;

    // Both masks are maximal-length for an 8-bit left-shifting Fibonacci LFSR
    localparam logic [7:0] SC_SEED_A = 8'd1;
    localparam logic [7:0] SC_SEED_B = 8'd244;
    localparam logic [7:0] SC_TAPS_A = 8'b1000_1110;
    localparam logic [7:0] SC_TAPS_B = 8'b1001_0101;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sc_state_t;

endpackage

`default_nettype wire

// File: rtl/sc_lfsr.sv
// ============================================================================
// sc_lfsr : left-shifting Fibonacci LFSR with synchronous load and step
// Revision: 1.0
// ============================================================================
`default_nettype none

module sc_lfsr
    import sc_pkg::*;
#(
    parameter int               WIDTH = SC_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = SC_TAPS_A,
    parameter logic [WIDTH-1:0] SEED  = SC_SEED_A
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEED;
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= {state[WIDTH-2:0], ^(state & TAPS)};
        end
    end

endmodule

`default_nettype wire

// File: rtl/sc_sng_pair.sv
// ============================================================================
// sc_sng_pair : dual-lane stochastic number generator with valid/ready output
// Optional macro SC_SNG_SEED_LOAD_EN adds per-start seed_a/seed_b inputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sc_sng_pair
    import sc_pkg::*;
#(
    parameter int               WIDTH  = SC_WIDTH,
    parameter int               BSL    = SC_BSL,
    parameter logic [WIDTH-1:0] SEED_A = SC_SEED_A,
    parameter logic [WIDTH-1:0] SEED_B = SC_SEED_B,
    parameter logic [WIDTH-1:0] TAPS_A = SC_TAPS_A,
    parameter logic [WIDTH-1:0] TAPS_B = SC_TAPS_B
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SC_SNG_SEED_LOAD_EN
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
`endif
    output logic             idle,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             a_bit,
    output logic             b_bit,
    output logic             bit_last,
    output logic             done
);

    localparam int             CW   = $clog2(BSL + 1);
    localparam logic [CW-1:0]  LAST = CW'(BSL - 1);

    sc_state_t        state;
    sc_state_t        state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] lfsr_a;
    logic [WIDTH-1:0] lfsr_b;
    logic [WIDTH-1:0] reload_a;
    logic [WIDTH-1:0] reload_b;
    logic             accept;
    logic             xfer;
    logic             at_last;

`ifdef SC_SNG_SEED_LOAD_EN
    // A zero seed would lock the LFSR, so fall back to the parameter seed
    assign reload_a = (seed_a != '0) ? seed_a : SEED_A;
    assign reload_b = (seed_b != '0) ? seed_b : SEED_B;
`else
    assign reload_a = SEED_A;
    assign reload_b = SEED_B;
`endif

    assign accept  = (state == IDLE) && start;
    assign xfer    = (state == RUN) && bit_ready;
    assign at_last = (state == RUN) && (count == LAST);

    sc_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS_A),
        .SEED  (SEED_A)
    ) u_lfsr_a (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (reload_a),
        .step     (xfer),
        .state    (lfsr_a)
    );

    sc_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS_B),
        .SEED  (SEED_B)
    ) u_lfsr_b (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (reload_b),
        .step     (xfer),
        .state    (lfsr_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            count <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= xfer && at_last;
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                count <= '0;
            end else if (xfer) begin
                // Width holds BSL, so the final increment cannot wrap
                count <= count + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        idle       = 1'b0;
        bit_valid  = 1'b0;
        a_bit      = 1'b0;
        b_bit      = 1'b0;
        bit_last   = 1'b0;
        case (state)
            IDLE: begin
                idle = 1'b1;
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                bit_valid = 1'b1;
                a_bit     = (a_q > lfsr_a);
                b_bit     = (b_q > lfsr_b);
                bit_last  = at_last;
                if (xfer && at_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_sc_sng_pair.sv
// ============================================================================
// tb_sc_sng_pair : self-checking bench for sc_sng_pair (BSL=255 and BSL=1)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sc_sng_pair;
    import sc_pkg::*;

    localparam int BSL = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       bit_ready = 1'b0;
    logic       rdy1 = 1'b0;
`ifdef SC_SNG_SEED_LOAD_EN
    logic [7:0] seed_a = '0;
    logic [7:0] seed_b = '0;
`endif
    logic idle, bit_valid, a_bit, b_bit, bit_last, done;
    logic idle1, valid1, a_bit1, b_bit1, last1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sc_sng_pair #(.BSL(BSL)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef SC_SNG_SEED_LOAD_EN
        .seed_a    (seed_a),
        .seed_b    (seed_b),
`endif
        .idle      (idle),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .bit_last  (bit_last),
        .done      (done)
    );

    sc_sng_pair #(.BSL(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .a         (a),
        .b         (b),
`ifdef SC_SNG_SEED_LOAD_EN
        .seed_a    (seed_a),
        .seed_b    (seed_b),
`endif
        .idle      (idle1),
        .bit_valid (valid1),
        .bit_ready (rdy1),
        .a_bit     (a_bit1),
        .b_bit     (b_bit1),
        .bit_last  (last1),
        .done      (done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference LFSR step: double, drop bit 8, append parity of tapped bits
    function automatic logic [7:0] model_next(input logic [7:0] x, input logic [7:0] taps);
        int v;
        v = (int'(x) * 2) % 256 + ($countones(x & taps) % 2);
        return 8'(v);
    endfunction

    function automatic logic [7:0] eff_seed_a();
`ifdef SC_SNG_SEED_LOAD_EN
        return (seed_a != 0) ? seed_a : SC_SEED_A;
`else
        return SC_SEED_A;
`endif
    endfunction

    function automatic logic [7:0] eff_seed_b();
`ifdef SC_SNG_SEED_LOAD_EN
        return (seed_b != 0) ? seed_b : SC_SEED_B;
`else
        return SC_SEED_B;
`endif
    endfunction

    // One full stream on the BSL=255 instance; glitch mode toggles start and operands mid-stream
    task automatic run_stream(input logic [7:0] op_a, input logic [7:0] op_b, input int ready_pct,
                              input bit glitch, input int exp_a, input int exp_b, input string tag);
        logic [7:0] ma, mb;
        logic [2:0] prev;
        bit         have_prev = 0;
        int idx = 0, cyc = 0, ones_a = 0, ones_b = 0;
        int bit_err = 0, last_err = 0, hold_err = 0, valid_err = 0, done_err = 0;
        check({tag, " idle_before_start"}, idle, 1);
        ma = eff_seed_a();
        mb = eff_seed_b();
        start = 1'b1; a = op_a; b = op_b; bit_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check({tag, " first_valid_latency"}, bit_valid, 1);
        while (idx < BSL && cyc < 5000) begin
            if (bit_valid !== 1'b1) valid_err++;
            if (done !== 1'b0) done_err++;
            if (have_prev && ({a_bit, b_bit, bit_last} !== prev)) hold_err++;
            bit_ready = ($urandom_range(99) < ready_pct);
            if (glitch) begin
                a = 8'($urandom);
                b = 8'($urandom);
                start = (idx == 50) || (idx == BSL - 1);
            end
            if (bit_ready && bit_valid) begin
                if (a_bit !== (op_a > ma) || b_bit !== (op_b > mb)) bit_err++;
                if (bit_last !== (idx == BSL - 1)) last_err++;
                ones_a += int'(a_bit);
                ones_b += int'(b_bit);
                ma = model_next(ma, SC_TAPS_A);
                mb = model_next(mb, SC_TAPS_B);
                idx++;
                have_prev = 0;
            end else begin
                have_prev = bit_valid;
                prev = {a_bit, b_bit, bit_last};
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; bit_ready = 1'b0;
        check({tag, " transfers"}, idx, BSL);
        check({tag, " valid_gaps"}, valid_err, 0);
        check({tag, " early_done"}, done_err, 0);
        check({tag, " stall_hold"}, hold_err, 0);
        check({tag, " bit_sequence"}, bit_err, 0);
        check({tag, " bit_last_pos"}, last_err, 0);
        check({tag, " ones_a"}, ones_a, exp_a);
        check({tag, " ones_b"}, ones_b, exp_b);
        check({tag, " done_valid_after_last"}, {done, bit_valid, idle}, 3'b101);
        @(negedge clk);
        check({tag, " done_single_no_restart"}, {done, bit_valid, idle}, 3'b001);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         ready_pct;
        bit         glitch;
        int         exp_a;
        int         exp_b;
    } vec_t;

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vecs[5];
        int   ra, rb;
        vecs[0] = '{8'd128, 8'd128, 100, 1'b0, 127, 127};
        vecs[1] = '{8'd0,   8'd255, 100, 1'b0, 0,   254};
        vecs[2] = '{8'd200, 8'd37,  50,  1'b0, 199, 36};
        vecs[3] = '{8'd200, 8'd37,  100, 1'b1, 199, 36};
        vecs[4] = '{8'd1,   8'd2,   70,  1'b1, 0,   1};

        // Reset state while still held in reset
        repeat (2) @(negedge clk);
        check("reset_outputs", {idle, bit_valid, a_bit, b_bit, bit_last, done}, 6'b100000);
        check("reset_outputs_bsl1", {idle1, valid1, a_bit1, b_bit1, last1, done1}, 6'b100000);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_stream(vecs[i].a, vecs[i].b, vecs[i].ready_pct, vecs[i].glitch,
                       vecs[i].exp_a, vecs[i].exp_b, $sformatf("vec%0d", i));

        for (int k = 0; k < 4; k++) begin
            ra = int'($urandom_range(255));
            rb = int'($urandom_range(255));
            run_stream(8'(ra), 8'(rb), int'($urandom_range(30, 100)), 1'b0,
                       (ra > 0) ? ra - 1 : 0, (rb > 0) ? rb - 1 : 0, $sformatf("rand%0d", k));
        end

        // Abort with reset after 100 transfers
        start = 1'b1; a = 8'd128; b = 8'd128;
        @(negedge clk);
        start = 1'b0; bit_ready = 1'b1;
        repeat (100) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("async_reset_outputs", {idle, bit_valid, a_bit, b_bit, bit_last, done}, 6'b100000);
        @(negedge clk);
        rst = 1'b1; bit_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_done_after_abort", {done, bit_valid}, 2'b00);
        end
        run_stream(8'd128, 8'd128, 100, 1'b0, 127, 127, "post_reset");

`ifdef SC_SNG_SEED_LOAD_EN
        seed_a = 8'h5A; seed_b = 8'h33;
        run_stream(8'd128, 8'd128, 60, 1'b0, 127, 127, "seed_load");
        seed_a = 8'h00; seed_b = 8'h00;
        run_stream(8'd128, 8'd128, 100, 1'b0, 127, 127, "seed_zero");
`endif

        // BSL=1: stall two cycles, then a single final transfer
        a = 8'd200; b = 8'd3; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("bsl1_first", {valid1, last1, a_bit1, b_bit1},
              {1'b1, 1'b1, (8'd200 > eff_seed_a()), (8'd3 > eff_seed_b())});
        a = 8'd0; b = 8'd0;
        repeat (2) @(negedge clk);
        check("bsl1_stall_hold", {valid1, last1, a_bit1, b_bit1, done1},
              {1'b1, 1'b1, (8'd200 > eff_seed_a()), (8'd3 > eff_seed_b()), 1'b0});
        rdy1 = 1'b1;
        @(negedge clk);
        rdy1 = 1'b0;
        check("bsl1_done", {done1, valid1, idle1}, 3'b101);
        @(negedge clk);
        check("bsl1_done_cleared", {done1, valid1}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
